// File: rtl/median_pkg.sv
// Shared parameters and types for the 7-sample streaming median block.
package median_pkg;

  localparam int DATA_W  = 4;
  localparam int NUM     = 7;
  localparam int MID_IDX = 3;
  localparam int CNT_W   = 3;

  typedef enum logic {
    LOAD = 1'b0,
    OUT  = 1'b1
  } state_t;

  typedef logic [DATA_W-1:0] sample_t;

endpackage

// File: rtl/median_sort_cell.sv
// One slot of the ascending insertion-sort array.
// The cell decides its next value from the incoming sample, its own value and
// its left neighbour.
// - If the left neighbour holds a value strictly greater than the sample, that
//   value shifts right into this slot.
// - Otherwise, if this slot holds a value strictly greater than the sample, or
//   the slot is empty while the left neighbour is occupied, this slot takes
//   the sample.
// - Otherwise it keeps its value.
// Strict compares place an equal sample after existing equal entries.
// Slot 0 is wired with an always-occupied left neighbour of value 0. Because
// 0 is never greater than a sample, slot 0 takes the sample when it is empty.
module median_sort_cell
  import median_pkg::*;
(
  input  logic [DATA_W-1:0] sample,
  input  logic [DATA_W-1:0] self_val,
  input  logic              self_occ,
  input  logic [DATA_W-1:0] left_val,
  input  logic              left_occ,
  output logic [DATA_W-1:0] next_val
);

  logic left_gt;
  logic self_gt;

  assign left_gt = left_occ && (left_val > sample);
  assign self_gt = self_occ && (self_val > sample);

  // Shift from left, take the sample, or hold.
  always_comb begin
    next_val = self_val;
    if (left_gt) begin
      next_val = left_val;
    end else if (self_gt || (!self_occ && left_occ)) begin
      next_val = sample;
    end
  end

endmodule

// File: rtl/median_stream_7num.sv
// Streaming median of 7 serial 4-bit samples.
// Samples are insertion-sorted into a 7-entry register array as they arrive.
// The median is taken from rank 3 of that array.
// Optional feature macro: MEDIAN_MINMAX_EN adds min_out and max_out.
//
// state | meaning
// LOAD  | accepting samples, in_ready=1, out_valid=0
// OUT   | frame complete, median presented, waiting for out_ready
module median_stream_7num
  import median_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] median,
  output logic              out_valid,
  input  logic              out_ready
`ifdef MEDIAN_MINMAX_EN
  ,
  output logic [DATA_W-1:0] min_out,
  output logic [DATA_W-1:0] max_out
`endif
);

  state_t                       state;
  logic [CNT_W-1:0]             count;
  logic [NUM-1:0][DATA_W-1:0]   sorted_q;
  logic [NUM-1:0][DATA_W-1:0]   sorted_nxt;
  logic [NUM-1:0]               occ;
  logic                         accept;

  // in_ready is a registered copy of (state == LOAD).
  assign accept = in_valid && in_ready;

  genvar gi;
  generate
    for (gi = 0; gi < NUM; gi++) begin : g_cell
      assign occ[gi] = (count > CNT_W'(gi));

      if (gi == 0) begin : g_first
        median_sort_cell u_cell (
          .sample   (in_data),
          .self_val (sorted_q[gi]),
          .self_occ (occ[gi]),
          .left_val ('0),
          .left_occ (1'b1),
          .next_val (sorted_nxt[gi])
        );
      end else begin : g_rest
        median_sort_cell u_cell (
          .sample   (in_data),
          .self_val (sorted_q[gi]),
          .self_occ (occ[gi]),
          .left_val (sorted_q[gi-1]),
          .left_occ (occ[gi-1]),
          .next_val (sorted_nxt[gi])
        );
      end
    end
  endgenerate

  // FSM, sample count, sorted array and handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= LOAD;
      count     <= '0;
      sorted_q  <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (accept) begin
            sorted_q <= sorted_nxt;
            count    <= count + CNT_W'(1);
            if (count == CNT_W'(NUM - 1)) begin
              state     <= OUT;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        OUT: begin
          if (out_ready) begin
            state     <= LOAD;
            count     <= '0;
            sorted_q  <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= LOAD;
          count     <= '0;
          sorted_q  <= '0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Results come straight from the array flops, so they stay stable while in OUT.
  assign median = sorted_q[MID_IDX];

`ifdef MEDIAN_MINMAX_EN
  assign min_out = sorted_q[0];
  assign max_out = sorted_q[NUM-1];
`endif

endmodule

// File: tb/tb_median_stream_7num.sv
// Scoreboard bench for median_stream_7num.
// The driver pushes each full frame's sorted-order expectation when it issues
// the frame. A negedge monitor models the LOAD/OUT handshake protocol, compares
// outputs every cycle, and pops one expectation per out handshake.
module tb_median_stream_7num;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] in_data = 4'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] median;
  logic       out_valid;
  logic       out_ready = 1'b0;
`ifdef MEDIAN_MINMAX_EN
  logic [3:0] min_out;
  logic [3:0] max_out;
`endif

  typedef struct {
    int med;
    int mn;
    int mx;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_frames = 0;
  int   n_hs     = 0;
  int   m_cnt    = 0;
  bit   m_busy   = 1'b0;

  median_stream_7num dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .median    (median),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef MEDIAN_MINMAX_EN
    ,
    .min_out   (min_out),
    .max_out   (max_out)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Protocol model and scoreboard compare
  always @(negedge clk) begin
    if (reset) begin
      m_cnt  = 0;
      m_busy = 1'b0;
    end else begin
      chk("out_valid", int'(out_valid), int'(m_busy));
      chk("in_ready", int'(in_ready), int'(!m_busy));
      if (m_busy) begin
        if (sb.size() == 0) begin
          fail_now("unexpected_result");
        end else begin
          chk("median", int'(median), sb[0].med);
`ifdef MEDIAN_MINMAX_EN
          chk("min_out", int'(min_out), sb[0].mn);
          chk("max_out", int'(max_out), sb[0].mx);
`endif
          if (out_ready) begin
            void'(sb.pop_front());
            n_hs++;
            m_busy = 1'b0;
          end
        end
      end else if (in_valid) begin
        m_cnt++;
        if (m_cnt == 7) begin
          m_busy = 1'b1;
          m_cnt  = 0;
        end
      end
    end
  end

  task automatic drive_sample(input logic [3:0] d, input int max_gap);
    int  n;
    int  bound;
    bit  ok;
    n = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    repeat (n) begin
      in_valid = 1'b0;
      in_data  = 4'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    bound    = 0;
    ok       = 1'b0;
    while (!ok && bound < 50) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
      bound++;
    end
    if (!ok) fail_now("accept_timeout");
    in_valid = 1'b0;
    in_data  = 4'($urandom);
  endtask

  task automatic send_frame(input int v0, input int v1, input int v2, input int v3,
                            input int v4, input int v5, input int v6,
                            input int max_gap, input int hold);
    int   vals[$];
    int   srt[$];
    exp_t e;
    int   k;
    vals = '{v0, v1, v2, v3, v4, v5, v6};
    srt  = vals;
    srt.sort();
    e.med = srt[3];
    e.mn  = srt[0];
    e.mx  = srt[6];
    sb.push_back(e);
    n_frames++;
    out_ready = (hold == 0);
    foreach (vals[i]) drive_sample(4'(vals[i]), max_gap);
    k = 0;
    while (1) begin
      @(negedge clk);
      if (out_valid) break;
      k++;
      if (k > 20) begin
        fail_now("result_timeout");
        break;
      end
    end
    if (hold > 0) begin
      repeat (hold) begin
        @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end else begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_random_frame(input int max_gap, input int hold);
    int r[7];
    int top;
    top = ($urandom_range(1, 0) == 1) ? 3 : 15;
    foreach (r[i]) r[i] = int'($urandom_range(top, 0));
    send_frame(r[0], r[1], r[2], r[3], r[4], r[5], r[6], max_gap, hold);
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_median", int'(median), 0);
`ifdef MEDIAN_MINMAX_EN
    chk("reset_min", int'(min_out), 0);
    chk("reset_max", int'(max_out), 0);
`endif
    @(posedge clk); #1;

    send_frame(3, 7, 1, 9, 4, 6, 2, 0, 0);
    send_frame(5, 5, 5, 5, 5, 5, 5, 0, 0);
    send_frame(0, 15, 0, 15, 0, 15, 8, 0, 0);
    send_frame(2, 11, 7, 7, 13, 0, 4, 3, 5);

    // Partial frame discarded by reset
    drive_sample(4'd1, 0);
    drive_sample(4'd2, 1);
    drive_sample(4'd14, 0);
    drive_sample(4'd15, 2);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    send_frame(9, 8, 7, 6, 5, 4, 3, 1, 0);

    send_frame(15, 14, 13, 12, 11, 10, 9, 0, 0);
    send_frame(0, 1, 2, 3, 4, 5, 6, 0, 0);

    for (int f = 0; f < 30; f++) begin
      send_random_frame(int'($urandom_range(3, 0)), int'($urandom_range(3, 0)));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("handshakes_per_frame", n_hs, n_frames);
    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule
